coin_acceptor: RTL and testbench

//  Front end that drives the coin inputs of the vending machine core.
//  - Synchronises and debounces the two raw, bouncy coin-slot sensors.
//  - Classifies each inserted coin as Rs5 or Rs10.
//  - Emits exactly one single-cycle rs_5_in / rs_10_in pulse per accepted coin.
//  - Rejects invalid insertions (both sensors, glitch, accept disabled) with a coin_reject pulse.

---
 rtl/coin_acceptor_if.sv | 27 ++
 rtl/coin_acceptor.sv | 147 ++++++++++++++
 tb/tb_coin_acceptor.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/coin_acceptor_if.sv
// Coin-slot bundle: raw sensors and enable in, credit pulses,
// status and counters out.
interface coin_acceptor_if #(
   parameter int CNT_W = 8
);
   logic             coin_5_raw;
   logic             coin_10_raw;
   logic             accept_en;
   logic             rs_5_in;
   logic             rs_10_in;
   logic             coin_reject;
   logic             busy;
   logic [CNT_W-1:0] accept_count;
   logic [CNT_W-1:0] reject_count;

   modport master (
      output coin_5_raw, coin_10_raw, accept_en,
      input  rs_5_in, rs_10_in, coin_reject, busy,
      input  accept_count, reject_count
   );

   modport slave (
      input  coin_5_raw, coin_10_raw, accept_en,
      output rs_5_in, rs_10_in, coin_reject, busy,
      output accept_count, reject_count
   );
endinterface

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: sync, debounce, classify and credit
// Rs5/Rs10 coins with single-cycle pulses and saturating counters.
module coin_acceptor #(
   parameter int DEBOUNCE = 4,
   parameter int MIN_GAP  = 8,
   parameter int CNT_W    = 8
) (
   input logic            clock,
   input logic            reset,
   coin_acceptor_if.slave bus
);
   localparam int MAXC = (DEBOUNCE > MIN_GAP) ? DEBOUNCE : MIN_GAP;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic [2:0] {
      IDLE, QUAL, EMIT, REJECT, RELEASE, GAP
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [1:0]       sync5_q, sync5_d;
   logic [1:0]       sync10_q, sync10_d;
   logic             coin10_q, coin10_d;
   logic             rs5_q, rs5_d;
   logic             rs10_q, rs10_d;
   logic             rej_q, rej_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] rejc_q, rejc_d;

   logic s5, s10, hit, other;

   assign s5    = sync5_q[1];
   assign s10   = sync10_q[1];
   assign hit   = coin10_q ? s10 : s5;
   assign other = coin10_q ? s5 : s10;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      coin10_d = coin10_q;
      rs5_d    = 1'b0;
      rs10_d   = 1'b0;
      rej_d    = 1'b0;
      acc_d    = acc_q;
      rejc_d   = rejc_q;
      sync5_d  = {sync5_q[0], bus.coin_5_raw};
      sync10_d = {sync10_q[0], bus.coin_10_raw};
      unique case (state_q)
         IDLE: begin
            if (s5 && s10) begin
               state_d = REJECT;
            end else if (s5 ^ s10) begin
               state_d  = QUAL;
               coin10_d = s10;
               cnt_d    = CW'(1);
            end
         end
         QUAL: begin
            if (hit && !other) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(DEBOUNCE - 1))
                  state_d = EMIT;
            end else begin
               state_d = REJECT;
            end
         end
         EMIT: begin
            if (bus.accept_en) begin
               rs5_d  = !coin10_q;
               rs10_d = coin10_q;
               acc_d  = (&acc_q) ? acc_q : acc_q + 1'b1;
            end else begin
               rej_d  = 1'b1;
               rejc_d = (&rejc_q) ? rejc_q : rejc_q + 1'b1;
            end
            state_d = RELEASE;
            cnt_d   = '0;
         end
         REJECT: begin
            rej_d   = 1'b1;
            rejc_d  = (&rejc_q) ? rejc_q : rejc_q + 1'b1;
            state_d = RELEASE;
            cnt_d   = '0;
         end
         RELEASE: begin
            // any sensor activity restarts the quiet window
            if (s5 || s10) begin
               cnt_d = '0;
            end else if (cnt_q == CW'(DEBOUNCE - 1)) begin
               state_d = GAP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         GAP: begin
            if (cnt_q == CW'(MIN_GAP - 1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         sync5_q  <= '0;
         sync10_q <= '0;
         coin10_q <= 1'b0;
         rs5_q    <= 1'b0;
         rs10_q   <= 1'b0;
         rej_q    <= 1'b0;
         busy_q   <= 1'b0;
         acc_q    <= '0;
         rejc_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sync5_q  <= sync5_d;
         sync10_q <= sync10_d;
         coin10_q <= coin10_d;
         rs5_q    <= rs5_d;
         rs10_q   <= rs10_d;
         rej_q    <= rej_d;
         busy_q   <= busy_d;
         acc_q    <= acc_d;
         rejc_q   <= rejc_d;
      end
   end

   assign bus.rs_5_in      = rs5_q;
   assign bus.rs_10_in     = rs10_q;
   assign bus.coin_reject  = rej_q;
   assign bus.busy         = busy_q;
   assign bus.accept_count = acc_q;
   assign bus.reject_count = rejc_q;
endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: latency, glitch, dual-sensor,
// disabled accept, back-to-back coins, mid-coin reset, saturation.
module tb_coin_acceptor;
   logic clk = 1'b0;
   logic reset;

   coin_acceptor_if #(.CNT_W(8)) bus ();

   coin_acceptor #(
      .DEBOUNCE(4), .MIN_GAP(8), .CNT_W(8)
   ) dut (
      .clock(clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int n5 = 0, n10 = 0, nrej = 0, viol = 0;
   logic [2:0] prev = '0;

   // pulse tally plus exclusivity / single-cycle watch
   always @(negedge clk) begin
      logic [2:0] p;
      p = {bus.rs_5_in, bus.rs_10_in, bus.coin_reject};
      if (p[2] === 1'b1) n5++;
      if (p[1] === 1'b1) n10++;
      if (p[0] === 1'b1) nrej++;
      if ($countones(p) > 1 || (p & prev) != 3'b000) viol++;
      prev = p;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      repeat (3) step();
      while (bus.busy !== 1'b0 && n < 60) begin
         step();
         n++;
      end
      chk(tag, 32'(n < 60), 32'd1);
   endtask

   int b5, b10, brej;

   task automatic snap();
      b5   = n5;
      b10  = n10;
      brej = nrej;
   endtask

   initial begin
      reset           = 1'b0;
      bus.coin_5_raw  = 1'b0;
      bus.coin_10_raw = 1'b0;
      bus.accept_en   = 1'b1;
      step();
      chk("rst_rs5",  32'(bus.rs_5_in),      32'd0);
      chk("rst_rs10", 32'(bus.rs_10_in),     32'd0);
      chk("rst_rej",  32'(bus.coin_reject),  32'd0);
      chk("rst_busy", 32'(bus.busy),         32'd0);
      chk("rst_acc",  32'(bus.accept_count), 32'd0);
      chk("rst_rjc",  32'(bus.reject_count), 32'd0);
      reset = 1'b1;
      step();
      step();

      // single Rs5 coin, exact pulse slot
      snap();
      bus.coin_5_raw = 1'b1;
      repeat (6) step();
      chk("t1_pre",   32'(bus.rs_5_in), 32'd0);
      step();
      chk("t1_pulse", 32'(bus.rs_5_in), 32'd1);
      chk("t1_acc",   32'(bus.accept_count), 32'd1);
      step();
      chk("t1_post",  32'(bus.rs_5_in), 32'd0);
      repeat (2) step();
      bus.coin_5_raw = 1'b0;
      wait_idle("t1_idle");
      chk("t1_n5",  32'(n5 - b5),     32'd1);
      chk("t1_rej", 32'(nrej - brej), 32'd0);
      chk("t1_rjc", 32'(bus.reject_count), 32'd0);

      // Rs10 bounce rejected, later steady insertion accepted
      snap();
      bus.coin_10_raw = 1'b1; step();
      bus.coin_10_raw = 1'b0; step();
      bus.coin_10_raw = 1'b1; step();
      bus.coin_10_raw = 1'b0; step();
      wait_idle("t2_idle_a");
      bus.coin_10_raw = 1'b1;
      repeat (10) step();
      bus.coin_10_raw = 1'b0;
      wait_idle("t2_idle_b");
      chk("t2_n10", 32'(n10 - b10),   32'd1);
      chk("t2_rej", 32'(nrej - brej), 32'd1);
      chk("t2_rjc", 32'(bus.reject_count), 32'd1);
      chk("t2_acc", 32'(bus.accept_count), 32'd2);

      // both sensors together
      snap();
      bus.coin_5_raw  = 1'b1;
      bus.coin_10_raw = 1'b1;
      repeat (10) step();
      bus.coin_5_raw  = 1'b0;
      bus.coin_10_raw = 1'b0;
      wait_idle("t3_idle");
      chk("t3_n5",  32'(n5 - b5),     32'd0);
      chk("t3_n10", 32'(n10 - b10),   32'd0);
      chk("t3_rej", 32'(nrej - brej), 32'd1);
      chk("t3_rjc", 32'(bus.reject_count), 32'd2);

      // accept disabled: reject lands in the EMIT slot
      snap();
      bus.accept_en   = 1'b0;
      bus.coin_10_raw = 1'b1;
      repeat (6) step();
      chk("t4_pre",  32'(bus.coin_reject), 32'd0);
      step();
      chk("t4_rej",  32'(bus.coin_reject), 32'd1);
      chk("t4_rs10", 32'(bus.rs_10_in),    32'd0);
      repeat (3) step();
      bus.coin_10_raw = 1'b0;
      wait_idle("t4_idle");
      bus.accept_en = 1'b1;
      chk("t4_acc", 32'(bus.accept_count), 32'd2);
      chk("t4_rjc", 32'(bus.reject_count), 32'd3);
      chk("t4_n10", 32'(n10 - b10), 32'd0);

      // second coin arrives during RELEASE and is absorbed
      snap();
      bus.coin_5_raw = 1'b1; repeat (10) step();
      bus.coin_5_raw = 1'b0; repeat (3) step();
      bus.coin_5_raw = 1'b1; repeat (10) step();
      bus.coin_5_raw = 1'b0;
      wait_idle("t5_idle");
      chk("t5_n5",  32'(n5 - b5),     32'd1);
      chk("t5_rej", 32'(nrej - brej), 32'd0);
      chk("t5_acc", 32'(bus.accept_count), 32'd3);

      // reset while qualifying
      snap();
      bus.coin_5_raw = 1'b1;
      repeat (3) step();
      chk("t6_busy_q", 32'(bus.busy), 32'd1);
      reset = 1'b0;
      #1;
      chk("t6_busy", 32'(bus.busy),         32'd0);
      chk("t6_acc",  32'(bus.accept_count), 32'd0);
      chk("t6_rjc",  32'(bus.reject_count), 32'd0);
      bus.coin_5_raw = 1'b0;
      step();
      step();
      reset = 1'b1;
      repeat (12) step();
      chk("t6_n5",  32'(n5 - b5),     32'd0);
      chk("t6_rej", 32'(nrej - brej), 32'd0);

      // saturation of accept_count
      snap();
      for (int c = 0; c < 257; c++) begin
         bus.coin_5_raw = 1'b1;
         repeat (6) step();
         bus.coin_5_raw = 1'b0;
         wait_idle("t7_idle");
         if (c == 254)
            chk("t7_acc255", 32'(bus.accept_count), 32'd255);
      end
      chk("t7_sat", 32'(bus.accept_count), 32'd255);
      chk("t7_n5",  32'(n5 - b5),          32'd257);
      chk("t7_rjc", 32'(bus.reject_count), 32'd0);

      chk("pulse_excl", 32'(viol), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
